// File: rtl/instr_encoder_pkg.sv
// Shared processor package: immediate-format codes, opcode constants and
// encode/decode immediate geometry used by the instruction encoder.
package instr_encoder_pkg;

  typedef enum logic [2:0] {
    FMT_LOAD   = 3'd0,
    FMT_STORE  = 3'd1,
    FMT_BRANCH = 3'd2,
    FMT_JUMP   = 3'd3
  } imm_fmt_t;

  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_JAL    = 7'h6F;

  // addi x0, x0, 0 -- substituted for any word that cannot be encoded
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Decode-side immediate geometry (sign bit position per format)
  localparam int IMM_I_MSB = 11;
  localparam int IMM_S_MSB = 11;
  localparam int IMM_B_MSB = 12;
  localparam int IMM_J_MSB = 20;

  // Stage-1 register contents; only imm[12:0] is ever packed
  typedef struct packed {
    logic        valid;
    logic [2:0]  fmt;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [12:0] imm;
    logic        ok;
  } s1_t;

  function automatic logic fmt_is_valid(input logic [2:0] fmt);
    return (fmt == FMT_LOAD) || (fmt == FMT_STORE) ||
           (fmt == FMT_BRANCH) || (fmt == FMT_JUMP);
  endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Request/response bus of the instruction encoder.
// Handshake: a word moves only on a clock edge where valid & ready are both 1;
// the source holds valid and payload stable until that edge, and ready never
// depends on valid.
interface instr_encoder_if;

  logic        in_valid;
  logic        in_ready;
  logic [2:0]  fmt;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [63:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] instr;
  logic        err;

  modport master (
    output in_valid, fmt, opcode, funct3, rd, rs1, rs2, imm, out_ready,
    input  in_ready, out_valid, instr, err
  );

  modport slave (
    input  in_valid, fmt, opcode, funct3, rd, rs1, rs2, imm, out_ready,
    output in_ready, out_valid, instr, err
  );

endinterface

// File: rtl/instr_encoder_range_chk.sv
// Combinational immediate range check: ok=1 when imm fits the format's field.
module imm_range_chk
  import instr_encoder_pkg::*;
(
  input  logic [63:0] imm,
  input  logic [2:0]  fmt,
  output logic        ok
);

  logic fits12;
  logic fits13;

  // Upper bits must be a pure sign extension of the field's top bit
  assign fits12 = (&imm[63:11]) | ~(|imm[63:11]);
  assign fits13 = (&imm[63:12]) | ~(|imm[63:12]);

  always_comb begin
    ok = 1'b0;
    case (fmt)
      FMT_LOAD, FMT_STORE, FMT_JUMP: ok = fits12;
      FMT_BRANCH:                    ok = fits13 & ~imm[0];
      default:                       ok = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Two-stage instruction encoder: S1 captures fields plus range result,
// S2 holds the packed word (or NOP with err) until the consumer takes it.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  instr_encoder_if.slave   bus,
  output logic [CNT_W-1:0] enc_count,
  output logic [CNT_W-1:0] err_count
);

  s1_t         s1Q;
  logic        rangeOk;
  logic        inFire;
  logic        s2Load;
  logic        outFire;
  logic [31:0] packedWord;
  logic        packErr;

  imm_range_chk u_range_chk (
    .imm (bus.imm),
    .fmt (bus.fmt),
    .ok  (rangeOk)
  );

  // S2 takes S1 whenever it is empty or is being drained this edge
  assign s2Load          = s1Q.valid & (~bus.out_valid | bus.out_ready);
  assign bus.in_ready    = ~s1Q.valid | ~bus.out_valid | bus.out_ready;
  assign inFire          = bus.in_valid & bus.in_ready;
  assign outFire         = bus.out_valid & bus.out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1Q <= '0;
    end else if (inFire) begin
      s1Q.valid  <= 1'b1;
      s1Q.fmt    <= bus.fmt;
      s1Q.opcode <= bus.opcode;
      s1Q.funct3 <= bus.funct3;
      s1Q.rd     <= bus.rd;
      s1Q.rs1    <= bus.rs1;
      s1Q.rs2    <= bus.rs2;
      s1Q.imm    <= bus.imm[12:0];
      s1Q.ok     <= rangeOk & fmt_is_valid(bus.fmt);
    end else if (s2Load) begin
      s1Q.valid <= 1'b0;
    end
  end

  always_comb begin
    packedWord = NOP_INSTR;
    packErr    = 1'b1;
    if (s1Q.ok) begin
      packErr = 1'b0;
      case (s1Q.fmt)
        FMT_LOAD, FMT_JUMP:
          packedWord = {s1Q.imm[11:0], s1Q.rs1, s1Q.funct3, s1Q.rd, s1Q.opcode};
        FMT_STORE:
          packedWord = {s1Q.imm[11:5], s1Q.rs2, s1Q.rs1, s1Q.funct3,
                        s1Q.imm[4:0], s1Q.opcode};
        FMT_BRANCH:
          packedWord = {s1Q.imm[12], s1Q.imm[10:5], s1Q.rs2, s1Q.rs1,
                        s1Q.funct3, s1Q.imm[4:1], s1Q.imm[11], s1Q.opcode};
        default: begin
          packedWord = NOP_INSTR;
          packErr    = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.out_valid <= 1'b0;
      bus.instr     <= '0;
      bus.err       <= 1'b0;
    end else if (s2Load) begin
      bus.out_valid <= 1'b1;
      bus.instr     <= packedWord;
      bus.err       <= packErr;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

  // Counters saturate rather than wrap so long runs stay monotonic
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      enc_count <= '0;
      err_count <= '0;
    end else if (outFire) begin
      if (bus.err) begin
        if (err_count != '1) err_count <= err_count + CNT_W'(1);
      end else begin
        if (enc_count != '1) enc_count <= enc_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: single words, range errors, a stalled
// back-to-back stream and reset with both stages full.
module tb_instr_encoder;

  localparam int CNT_W = 16;

  logic             clk;
  logic             reset_n;
  logic [CNT_W-1:0] enc_count;
  logic [CNT_W-1:0] err_count;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_q[$];

  instr_encoder_if bus ();

  instr_encoder #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .enc_count (enc_count),
    .err_count (err_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic drive_req(input logic [2:0] f, input logic [6:0] opc, input logic [2:0] f3,
                           input logic [4:0] rd_v, input logic [4:0] rs1_v,
                           input logic [4:0] rs2_v, input logic [63:0] im);
    bus.in_valid = 1'b1;
    bus.fmt      = f;
    bus.opcode   = opc;
    bus.funct3   = f3;
    bus.rd       = rd_v;
    bus.rs1      = rs1_v;
    bus.rs2      = rs2_v;
    bus.imm      = im;
  endtask

  task automatic send_single(input string tag, input logic [2:0] f, input logic [6:0] opc,
                             input logic [2:0] f3, input logic [4:0] rd_v,
                             input logic [4:0] rs1_v, input logic [4:0] rs2_v,
                             input logic [63:0] im, input logic [31:0] exp_instr,
                             input logic exp_err);
    @(negedge clk);
    bus.out_ready = 1'b1;
    drive_req(f, opc, f3, rd_v, rs1_v, rs2_v, im);
    #1 check({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1 check({tag, "_lat1"}, 64'(bus.out_valid), 64'd0);
    @(posedge clk);
    #1;
    check({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
    check({tag, "_instr"}, 64'(bus.instr), 64'(exp_instr));
    check({tag, "_err"}, 64'(bus.err), 64'(exp_err));
  endtask

  initial begin
    int          sent;
    int          got;
    logic        ready_dropped;
    logic        prev_hold;
    logic [31:0] prev_instr;
    logic [11:0] ei;
    logic        saw_valid;

    reset_n       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.fmt       = '0;
    bus.opcode    = '0;
    bus.funct3    = '0;
    bus.rd        = '0;
    bus.rs1       = '0;
    bus.rs2       = '0;
    bus.imm       = '0;

    #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_instr", 64'(bus.instr), 64'd0);
    check("rst_err", 64'(bus.err), 64'd0);
    check("rst_enc_count", 64'(enc_count), 64'd0);
    check("rst_err_count", 64'(err_count), 64'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    #1 check("rst_in_ready", 64'(bus.in_ready), 64'd1);

    // valid encodings
    send_single("load",   3'd0, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0, -64'sd1, 32'hFFF0_0093, 1'b0);
    send_single("store",  3'd1, 7'h23, 3'd3, 5'd0, 5'd3, 5'd2, 64'd8,   32'h0021_B423, 1'b0);
    send_single("branch", 3'd2, 7'h63, 3'd0, 5'd0, 5'd1, 5'd2, -64'sd4, 32'hFE20_8EE3, 1'b0);
    send_single("jalr",   3'd3, 7'h67, 3'd0, 5'd1, 5'd5, 5'd0, -64'sd2048, 32'h8002_80E7, 1'b0);
    @(posedge clk);
    #1;
    check("good_enc_count", 64'(enc_count), 64'd4);
    check("good_err_count", 64'(err_count), 64'd0);

    // out-of-range and invalid format
    send_single("load_2048",  3'd0, 7'h03, 3'd0, 5'd1, 5'd0, 5'd0, 64'd2048, 32'h0000_0013, 1'b1);
    send_single("branch_odd", 3'd2, 7'h63, 3'd0, 5'd0, 5'd1, 5'd2, 64'd3,    32'h0000_0013, 1'b1);
    send_single("fmt5",       3'd5, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 64'd0,    32'h0000_0013, 1'b1);
    @(posedge clk);
    #1;
    check("bad_err_count", 64'(err_count), 64'd3);
    check("bad_enc_count", 64'(enc_count), 64'd4);

    // back-to-back stream with a 3-cycle consumer stall
    sent          = 0;
    got           = 0;
    ready_dropped = 1'b0;
    prev_hold     = 1'b0;
    prev_instr    = '0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      bus.out_ready = !(c >= 5 && c < 8);
      if (sent < 8) drive_req(3'd0, 7'h03, 3'd2, 5'(sent + 1), 5'(sent), 5'd0, 64'(sent * 3));
      else bus.in_valid = 1'b0;
      #1;
      if (prev_hold) begin
        check("hold_valid", 64'(bus.out_valid), 64'd1);
        check("hold_instr", 64'(bus.instr), 64'(prev_instr));
      end
      if (!bus.in_ready) ready_dropped = 1'b1;
      if (bus.in_valid && bus.in_ready) begin
        ei = 12'(sent * 3);
        exp_q.push_back({ei, 5'(sent), 3'd2, 5'(sent + 1), 7'h03});
        sent++;
      end
      if (bus.out_valid && bus.out_ready) begin
        check("stream_q_nonempty", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) check("stream_word", 64'(bus.instr), 64'(exp_q.pop_front()));
        check("stream_err", 64'(bus.err), 64'd0);
        got++;
      end
      prev_hold  = bus.out_valid & ~bus.out_ready;
      prev_instr = bus.instr;
    end
    check("stream_sent", 64'(sent), 64'd8);
    check("stream_got", 64'(got), 64'd8);
    check("stream_ready_drop", 64'(ready_dropped), 64'd1);
    check("stream_q_empty", 64'(exp_q.size()), 64'd0);
    check("stream_enc_count", 64'(enc_count), 64'd12);
    check("stream_err_count", 64'(err_count), 64'd3);

    // fill both stages, then reset mid-cycle
    @(negedge clk);
    bus.out_ready = 1'b0;
    drive_req(3'd0, 7'h03, 3'd0, 5'd7, 5'd1, 5'd0, 64'd4);
    @(negedge clk);
    drive_req(3'd0, 7'h03, 3'd0, 5'd8, 5'd1, 5'd0, 64'd5);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    check("full_out_valid", 64'(bus.out_valid), 64'd1);
    check("full_in_ready", 64'(bus.in_ready), 64'd0);
    #1 reset_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("mid_rst_instr", 64'(bus.instr), 64'd0);
    check("mid_rst_enc_count", 64'(enc_count), 64'd0);
    check("mid_rst_err_count", 64'(err_count), 64'd0);
    check("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    reset_n       = 1'b1;
    bus.out_ready = 1'b1;
    saw_valid     = 1'b0;
    repeat (6) begin
      @(negedge clk);
      #1 saw_valid |= bus.out_valid;
    end
    check("post_rst_no_stale", 64'(saw_valid), 64'd0);

    send_single("post_rst", 3'd0, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0, -64'sd1, 32'hFFF0_0093, 1'b0);
    @(posedge clk);
    #1 check("post_rst_enc_count", 64'(enc_count), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 The module SHALL have parameter CNT_W, default 16, meaning the width of the encoded-word and error counters.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  request valid.
REQ-005 in_ready  output  1  encoder can accept a request this cycle.
REQ-006 fmt  input  3  immediate format: LOAD=0, STORE=1, BRANCH=2, JUMP=3 (jalr I-form); 4-7 invalid.
REQ-007 opcode  input  7  instr[6:0] field.
REQ-008 funct3  input  3  instr[14:12] field.
REQ-009 rd, rs1, rs2  input  5 each  register fields.
REQ-010 imm  input  64  sign-extended immediate to pack.
REQ-011 out_valid  output  1  encoded word valid.
REQ-012 out_ready  input  1  consumer accepts the word.
REQ-013 instr  output  32  encoded instruction.
REQ-014 err  output  1  qualifies instr: immediate out of range or fmt invalid.
REQ-015 enc_count  output  CNT_W  words delivered with err=0.
REQ-016 err_count  output  CNT_W  words delivered with err=1.

Function
REQ-017 The block SHALL be a 2-stage pipeline: S1 registers request fields and the range-check result; S2 registers the packed word, err, and out_valid.
REQ-018 Latency SHALL be 2 cycles from an accepted request (in_valid & in_ready) to out_valid, with no stalls.
REQ-019 Transfers SHALL occur only on valid&ready at a clock edge; out_valid, instr and err SHALL hold stable while out_valid=1 and out_ready=0.
REQ-020 in_ready SHALL equal !s1_valid | !s2_valid | out_ready (combinational, no dependency on in_valid); throughput SHALL be 1 word/cycle when out_ready=1.
REQ-021 Range: LOAD/STORE/JUMP SHALL require imm[63:11] all equal; BRANCH SHALL require imm[63:12] all equal and imm[0]=0.
REQ-022 LOAD/JUMP packing SHALL be {imm[11:0], rs1, funct3, rd, opcode}; rs2 ignored.
REQ-023 STORE packing SHALL be {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}; rd ignored.
REQ-024 BRANCH packing SHALL be {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}; rd ignored.
REQ-025 On a range failure or invalid fmt, instr SHALL be 32'h00000013 (NOP) with err=1; the word SHALL still be delivered and SHALL NOT stall the pipeline.
REQ-026 enc_count or err_count SHALL increment by 1 per output transfer according to err, saturating at all-ones.
REQ-027 Simultaneous S2 output transfer and S1-to-S2 advance SHALL lose no word and duplicate none.

Reset
REQ-028 While reset_n=0: s1_valid=0, out_valid=0, instr=0, err=0, enc_count=0, err_count=0; in_ready SHALL be 1 after reset.
REQ-029 Reset mid-operation SHALL discard in-flight words without emitting them; counters SHALL restart at 0.

Structure
REQ-030 Format codes (enum imm_fmt_t), opcode constants, and NOP_INSTR SHALL live in the shared processor package, alongside the decode-side immediate constants.
REQ-031 Range checking SHALL be a combinational sub-module imm_range_chk (imm, fmt -> ok), instantiated once in S1.

Verification
REQ-032 LOAD-form fmt=0, opcode=7'h13, funct3=0, rd=1, rs1=0, imm=-1 -> instr=32'hFFF00093, err=0, 2 cycles later.
REQ-033 STORE fmt=1, opcode=7'h23, funct3=3, rs1=3, rs2=2, imm=8 -> instr=32'h0021B423, err=0.
REQ-034 BRANCH fmt=2, opcode=7'h63, funct3=0, rs1=1, rs2=2, imm=-4 -> instr=32'hFE208EE3, err=0.
REQ-035 LOAD imm=2048; BRANCH imm=3; fmt=5 -> each instr=32'h00000013, err=1; err_count=3, enc_count unchanged.
REQ-036 Back-to-back 8 requests, out_ready low for 3 cycles mid-stream -> in_ready drops once both stages fill, output order preserved, words held stable while stalled, enc_count=8.
REQ-037 reset_n asserted with both stages full -> out_valid=0 immediately, no stale word after release, counters=0.
